// File: rtl/store_buffer.sv
// Speculative store FIFO between MEM and the D-cache write port. Drains only
// committed stores and forwards from buffered stores to younger loads.
package brisc_pkg;
    localparam int XLEN = 32;
endpackage

module store_buffer
    import brisc_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_valid_in,
    input  logic [ADDR_BITS-1:0] enq_addr_in,
    input  logic [XLEN-1:0]      enq_data_in,
    input  logic                 enq_byte_in,
    output logic                 full_out,
    input  logic                 stb_flush_in,
    output logic                 dc_req_out,
    output logic [ADDR_BITS-1:0] dc_addr_out,
    output logic [XLEN-1:0]      dc_data_out,
    output logic                 dc_byte_out,
    input  logic                 dc_ack_in,
    input  logic                 ld_valid_in,
    input  logic [ADDR_BITS-1:0] ld_addr_in,
    input  logic                 ld_byte_in,
    output logic                 fwd_hit_out,
    output logic [XLEN-1:0]      fwd_data_out,
    output logic                 fwd_stall_out
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [ADDR_BITS-1:0] addr_mem [NUM_ENTRIES];
    logic [XLEN-1:0]      data_mem [NUM_ENTRIES];
    logic                 byte_mem [NUM_ENTRIES];

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] commit_reg, commit_next;
    state_t           state_reg, state_next;
    logic             dc_req_reg;

    logic enq_fire;
    logic pop;
    logic flush_ok;

    assign full_out = (count_reg == CNT_W'(NUM_ENTRIES));
    assign enq_fire = enq_valid_in && !full_out;
    assign pop      = (state_reg == DRAIN) && dc_req_reg && dc_ack_in;
    assign flush_ok = stb_flush_in && (commit_reg != count_reg);

    always_comb begin
        count_next = count_reg;
        if (enq_fire && !pop)
            count_next = count_reg + CNT_W'(1);
        else if (!enq_fire && pop)
            count_next = count_reg - CNT_W'(1);
    end

    always_comb begin
        commit_next = commit_reg;
        if (flush_ok && !pop)
            commit_next = commit_reg + CNT_W'(1);
        else if (!flush_ok && pop)
            commit_next = commit_reg - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            commit_reg <= '0;
        end else begin
            if (enq_fire)
                tail_reg <= tail_reg + PTR_W'(1);
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            count_reg  <= count_next;
            commit_reg <= commit_next;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            addr_mem[tail_reg] <= enq_addr_in;
            data_mem[tail_reg] <= enq_data_in;
            byte_mem[tail_reg] <= enq_byte_in;
        end
    end

    // Drain FSM: state register, next-state logic, output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            dc_req_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dc_req_reg <= (state_next == DRAIN);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (commit_reg != '0) state_next = DRAIN;
            DRAIN:   if (pop)              state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dc_req_out  = dc_req_reg;
        dc_addr_out = '0;
        dc_data_out = '0;
        dc_byte_out = 1'b0;
        if (dc_req_reg) begin
            dc_addr_out = addr_mem[head_reg];
            dc_data_out = data_mem[head_reg];
            dc_byte_out = byte_mem[head_reg];
        end
    end

    // Per-slot word match, qualified by whether the slot lies inside [head, tail).
    logic [NUM_ENTRIES-1:0] slot_match;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_age;
            logic             slot_valid;
            assign slot_age      = PTR_W'(gi) - head_reg;
            assign slot_valid    = {1'b0, slot_age} < count_reg;
            assign slot_match[gi] = slot_valid &&
                (addr_mem[gi][ADDR_BITS-1:2] == ld_addr_in[ADDR_BITS-1:2]);
        end
    endgenerate

    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    logic [PTR_W-1:0] scan_idx;

    // Walk oldest to youngest so the youngest matching slot overrides.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (slot_match[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    logic [XLEN-1:0] sel_word;
    logic [7:0]      sel_lane;

    assign sel_word = data_mem[sel_idx];
    assign sel_lane = 8'(sel_word >> {ld_addr_in[1:0], 3'b000});

    always_comb begin
        fwd_hit_out   = 1'b0;
        fwd_stall_out = 1'b0;
        fwd_data_out  = '0;
        if (ld_valid_in && sel_found) begin
            if (!byte_mem[sel_idx]) begin
                fwd_hit_out  = 1'b1;
                fwd_data_out = ld_byte_in ? XLEN'(sel_lane) : sel_word;
            end else if (ld_byte_in && (addr_mem[sel_idx][1:0] == ld_addr_in[1:0])) begin
                fwd_hit_out  = 1'b1;
                fwd_data_out = XLEN'(sel_word[7:0]);
            end else begin
                fwd_stall_out = 1'b1;
            end
        end
    end

endmodule
